// File: rtl/vio_pkg.sv
// Shared types and constants for the VIO command responder.
// VIO_HDR_CHECK_EN adds the CHECK state (header followed by its one's complement).
package vio_pkg;

  localparam int DATA_W = 16;
  localparam logic [3:0] STATUS_SIG = 4'hA;

  localparam int ST_BUSY    = 11;
  localparam int ST_OVF     = 10;
  localparam int ST_BAD_OP  = 9;
  localparam int ST_CHK_ERR = 8;

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_WRITE  = 4'd1,
    OP_READ   = 4'd2,
    OP_CLRERR = 4'd3
  } opcode_e;

`ifdef VIO_HDR_CHECK_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_CHECK = 2'd2, S_PAYLOAD = 2'd3} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_PAYLOAD = 2'd3} state_e;
`endif

  function automatic logic [DATA_W-1:0] status_word(input logic busy, input logic ovf,
                                                    input logic bad_op, input logic chk_err,
                                                    input logic [3:0] cnt);
    logic [DATA_W-1:0] w;
    w = '0;
    w[15:12]    = STATUS_SIG;
    w[ST_BUSY]    = busy;
    w[ST_OVF]     = ovf;
    w[ST_BAD_OP]  = bad_op;
    w[ST_CHK_ERR] = chk_err;
    w[3:0]      = cnt;
    return w;
  endfunction

endpackage

// File: rtl/vio_fifo.sv
// Fall-through command-word FIFO; a push into a full FIFO succeeds only alongside a pop.
module vio_fifo
  import vio_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              push_ok, pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vio_responder.sv
// Host-link command responder: queues strobed words, decodes NOP/WRITE/READ/CLRERR into a 16x16 register file.
// VIO_HDR_CHECK_EN requires each header to be followed by its one's complement.
module vio_responder
  import vio_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vio_en,
  input  logic        vio_strobe,
  input  logic [15:0] vio_din,
  output logic [15:0] vio_dout,
  output logic [15:0] vio_cfg,
  output logic        reg_wr,
  output logic [3:0]  reg_addr,
  output logic [15:0] reg_data
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic [15:0]   fifo_dout;
  logic          push, pop, drop;

  state_e        state;
  logic [15:0]   regs [16];
  logic [3:0]    addr_q;
  logic [7:0]    cnt_q;
  logic [15:0]   resp;
  logic          resp_valid, ovf, bad_op, chk_bit, busy;

  logic [15:0]   cmd;
  logic [3:0]    cmd_op, cmd_addr;
  logic [7:0]    cmd_cnt;
  logic          exec, clr, bad;

  assign pop  = vio_en && !fifo_empty && (state != S_IDLE);
  assign push = vio_en && vio_strobe && (!fifo_full || pop);
  assign drop = vio_en && vio_strobe && fifo_full && !pop;

  vio_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (!vio_en),
    .push    (push),
    .pop     (pop),
    .din     (vio_din),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifdef VIO_HDR_CHECK_EN
  logic [15:0] hdr_q;
  logic        discard_q, chk_err, chk_ok;
  assign cmd     = hdr_q;
  assign chk_ok  = (fifo_dout == ~hdr_q);
  assign exec    = (state == S_CHECK) && pop && chk_ok;
  assign chk_bit = chk_err;
`else
  assign cmd     = fifo_dout;
  assign exec    = (state == S_HDR) && pop;
  assign chk_bit = 1'b0;
`endif

  assign cmd_op   = cmd[15:12];
  assign cmd_addr = cmd[11:8];
  assign cmd_cnt  = cmd[7:0];
  assign clr      = exec && (cmd_op == OP_CLRERR);
  assign bad      = exec && (cmd_op > OP_CLRERR);

  assign busy     = (state != S_IDLE) || !fifo_empty;
  assign vio_cfg  = regs[0];
  assign vio_dout = resp_valid ? resp : status_word(busy, ovf, bad_op, chk_bit, 4'(fifo_count));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      resp       <= '0;
      resp_valid <= 1'b0;
      ovf        <= 1'b0;
      bad_op     <= 1'b0;
      reg_wr     <= 1'b0;
      reg_addr   <= '0;
      reg_data   <= '0;
`ifdef VIO_HDR_CHECK_EN
      hdr_q      <= '0;
      discard_q  <= 1'b0;
      chk_err    <= 1'b0;
`endif
    end else begin
      reg_wr <= 1'b0;
      // A drop coinciding with CLRERR still leaves ovf set.
      ovf    <= (ovf && !clr) || drop;
      bad_op <= (bad_op && !clr) || bad;
      if (push) resp_valid <= 1'b0;

      if (!vio_en) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (!fifo_empty) state <= S_HDR;
          S_HDR: begin
`ifdef VIO_HDR_CHECK_EN
            hdr_q <= fifo_dout;
            state <= S_CHECK;
`else
            state <= S_IDLE;
`endif
          end
`ifdef VIO_HDR_CHECK_EN
          S_CHECK: begin
            // A failed check still consumes a WRITE's payload so the stream stays aligned.
            if (pop && !chk_ok) begin
              chk_err <= 1'b1;
              if (hdr_q[15:12] == OP_WRITE && hdr_q[7:0] != 8'd0) begin
                discard_q <= 1'b1;
                cnt_q     <= hdr_q[7:0];
                state     <= S_PAYLOAD;
              end else begin
                state <= S_IDLE;
              end
            end
          end
`endif
          S_PAYLOAD: begin
            if (pop) begin
`ifdef VIO_HDR_CHECK_EN
              if (!discard_q)
`endif
              begin
                regs[addr_q] <= fifo_dout;
                reg_wr       <= 1'b1;
                reg_addr     <= addr_q;
                reg_data     <= fifo_dout;
              end
              addr_q <= addr_q + 4'd1;
              cnt_q  <= cnt_q - 8'd1;
              if (cnt_q == 8'd1) state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase

        if (exec) begin
          state <= S_IDLE;
          case (cmd_op)
            OP_WRITE: begin
              if (cmd_cnt != 8'd0) begin
                addr_q <= cmd_addr;
                cnt_q  <= cmd_cnt;
`ifdef VIO_HDR_CHECK_EN
                discard_q <= 1'b0;
`endif
                state  <= S_PAYLOAD;
              end
            end
            OP_READ: begin
              resp       <= regs[cmd_addr];
              resp_valid <= 1'b1;
            end
`ifdef VIO_HDR_CHECK_EN
            OP_CLRERR: chk_err <= 1'b0;
`endif
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_vio_responder.sv
// Directed self-checking bench for vio_responder (default FIFO_DEPTH=8).
module tb_vio_responder;

`ifdef VIO_HDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk, reset_n, vio_en, vio_strobe;
  logic [15:0] vio_din, vio_dout, vio_cfg, reg_data;
  logic        reg_wr;
  logic [3:0]  reg_addr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] wq [$];
  logic [3:0]  log_addr [$];
  logic [15:0] log_data [$];

  vio_responder #(.FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .vio_en     (vio_en),
    .vio_strobe (vio_strobe),
    .vio_din    (vio_din),
    .vio_dout   (vio_dout),
    .vio_cfg    (vio_cfg),
    .reg_wr     (reg_wr),
    .reg_addr   (reg_addr),
    .reg_data   (reg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_wr) begin
      log_addr.push_back(reg_addr);
      log_data.push_back(reg_data);
    end
  end

  task automatic q_hdr(input logic [15:0] h);
    wq.push_back(h);
    if (CHK) wq.push_back(~h);
  endtask

  // Drives wq as back-to-back strobes starting at the current falling edge.
  task automatic send_q();
    foreach (wq[i]) begin
      vio_strobe = 1'b1;
      vio_din    = wq[i];
      @(negedge clk);
    end
    vio_strobe = 1'b0;
    wq.delete();
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic test_reset();
    n_checks++;
    if (vio_dout !== 16'hA000) begin n_fail++; $display("FAIL reset_dout: got %h expected %h", vio_dout, 16'hA000); end
    n_checks++;
    if (vio_cfg !== 16'h0000) begin n_fail++; $display("FAIL reset_cfg: got %h expected %h", vio_cfg, 16'h0000); end
    n_checks++;
    if ({reg_wr, reg_addr, reg_data} !== 21'd0) begin
      n_fail++; $display("FAIL reset_regif: got %b/%h/%h expected 0/0/0000", reg_wr, reg_addr, reg_data);
    end
  endtask

  task automatic test_write();
    clear_log();
    q_hdr(16'h1002); wq.push_back(16'h1234); wq.push_back(16'h5678);
    send_q();
    repeat (6) @(negedge clk);
    n_checks++;
    if (log_addr.size() != 2) begin
      n_fail++; $display("FAIL write_pulses: got %0d expected 2", log_addr.size());
    end else begin
      n_checks++;
      if ({log_addr[0], log_data[0]} !== {4'h0, 16'h1234}) begin
        n_fail++; $display("FAIL write_first: got %h/%h expected 0/1234", log_addr[0], log_data[0]);
      end
      n_checks++;
      if ({log_addr[1], log_data[1]} !== {4'h1, 16'h5678}) begin
        n_fail++; $display("FAIL write_second: got %h/%h expected 1/5678", log_addr[1], log_data[1]);
      end
    end
    n_checks++;
    if (vio_cfg !== 16'h1234) begin n_fail++; $display("FAIL write_cfg: got %h expected %h", vio_cfg, 16'h1234); end
  endtask

  task automatic test_read();
    bit seen;
    seen = 1'b0;
    q_hdr(16'h2100);
    send_q();
    for (int i = 0; i < 3; i++) begin
      if (vio_dout === 16'h5678) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen && vio_dout === 16'h5678) seen = 1'b1;
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL read_latency: got %h expected %h within 3 cycles", vio_dout, 16'h5678); end
    repeat (4) @(negedge clk);
    n_checks++;
    if (vio_dout !== 16'h5678) begin n_fail++; $display("FAIL read_hold: got %h expected %h", vio_dout, 16'h5678); end
    q_hdr(16'h0000);
    send_q();
    n_checks++;
    if (vio_dout !== (CHK ? 16'hA802 : 16'hA801)) begin
      n_fail++; $display("FAIL read_release: got %h expected %h", vio_dout, CHK ? 16'hA802 : 16'hA801);
    end
    repeat (6) @(negedge clk);
    n_checks++;
    if (vio_dout !== 16'hA000) begin n_fail++; $display("FAIL read_idle: got %h expected %h", vio_dout, 16'hA000); end
  endtask

  task automatic test_wrap();
    clear_log();
    q_hdr(16'h1F02); wq.push_back(16'hAAAA); wq.push_back(16'hBBBB);
    send_q();
    repeat (6) @(negedge clk);
    n_checks++;
    if (log_addr.size() != 2) begin
      n_fail++; $display("FAIL wrap_pulses: got %0d expected 2", log_addr.size());
    end else begin
      n_checks++;
      if ({log_addr[0], log_data[0], log_addr[1], log_data[1]} !== {4'hF, 16'hAAAA, 4'h0, 16'hBBBB}) begin
        n_fail++; $display("FAIL wrap_addr: got %h/%h %h/%h expected F/AAAA 0/BBBB",
                           log_addr[0], log_data[0], log_addr[1], log_data[1]);
      end
    end
    n_checks++;
    if (vio_cfg !== 16'hBBBB) begin n_fail++; $display("FAIL wrap_reg0: got %h expected %h", vio_cfg, 16'hBBBB); end
    q_hdr(16'h2F00);
    send_q();
    repeat (4) @(negedge clk);
    n_checks++;
    if (vio_dout !== 16'hAAAA) begin n_fail++; $display("FAIL wrap_reg15: got %h expected %h", vio_dout, 16'hAAAA); end
    q_hdr(16'h0000);
    send_q();
    repeat (6) @(negedge clk);
  endtask

  task automatic test_overflow();
    // The decoder drains one NOP per two cycles, so a steady stream outruns it and fills the FIFO.
    for (int i = 0; i < 24; i++) wq.push_back(16'h0000);
    send_q();
    n_checks++;
    if (vio_dout[11:10] !== 2'b11) begin n_fail++; $display("FAIL ovf_set: got %h expected busy=1 ovf=1", vio_dout); end
    vio_en = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (vio_dout !== (CHK ? 16'hA500 : 16'hA400)) begin
      n_fail++; $display("FAIL ovf_flush: got %h expected %h", vio_dout, CHK ? 16'hA500 : 16'hA400);
    end
    vio_en = 1'b1;
    @(negedge clk);
    q_hdr(16'h3000);
    send_q();
    repeat (6) @(negedge clk);
    n_checks++;
    if (vio_dout !== 16'hA000) begin n_fail++; $display("FAIL ovf_clear: got %h expected %h", vio_dout, 16'hA000); end
  endtask

  task automatic test_bad_op();
    q_hdr(16'h7000);
    send_q();
    repeat (6) @(negedge clk);
    n_checks++;
    if (vio_dout !== 16'hA200) begin n_fail++; $display("FAIL bad_op: got %h expected %h", vio_dout, 16'hA200); end
  endtask

  task automatic test_disable();
    clear_log();
    q_hdr(16'h1C03); wq.push_back(16'h1111); wq.push_back(16'h2222);
    send_q();
    vio_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (vio_dout !== 16'hA200) begin n_fail++; $display("FAIL disable_flush: got %h expected %h", vio_dout, 16'hA200); end
    vio_strobe = 1'b1; vio_din = 16'h0000;
    @(negedge clk);
    vio_strobe = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (vio_dout !== 16'hA200) begin n_fail++; $display("FAIL disable_ignore: got %h expected %h", vio_dout, 16'hA200); end
    n_checks++;
    if (log_addr.size() != 0) begin n_fail++; $display("FAIL disable_nowrite: got %0d expected 0", log_addr.size()); end
    vio_en = 1'b1;
    @(negedge clk);
    q_hdr(16'h2C00); send_q(); repeat (4) @(negedge clk);
    n_checks++;
    if (vio_dout !== 16'h0000) begin n_fail++; $display("FAIL disable_reg12: got %h expected %h", vio_dout, 16'h0000); end
    q_hdr(16'h2100); send_q(); repeat (4) @(negedge clk);
    n_checks++;
    if (vio_dout !== 16'h5678) begin n_fail++; $display("FAIL disable_reg1: got %h expected %h", vio_dout, 16'h5678); end
    n_checks++;
    if (vio_cfg !== 16'hBBBB) begin n_fail++; $display("FAIL disable_reg0: got %h expected %h", vio_cfg, 16'hBBBB); end
    q_hdr(16'h3000); send_q(); repeat (6) @(negedge clk);
    n_checks++;
    if (vio_dout !== 16'hA000) begin n_fail++; $display("FAIL disable_clrerr: got %h expected %h", vio_dout, 16'hA000); end
  endtask

`ifdef VIO_HDR_CHECK_EN
  task automatic test_check();
    clear_log();
    wq.push_back(16'h1001); wq.push_back(16'h0000); wq.push_back(16'hDEAD);
    send_q();
    repeat (6) @(negedge clk);
    n_checks++;
    if (vio_dout !== 16'hA100) begin n_fail++; $display("FAIL chk_err: got %h expected %h", vio_dout, 16'hA100); end
    n_checks++;
    if (vio_cfg !== 16'hBBBB) begin n_fail++; $display("FAIL chk_reg0: got %h expected %h", vio_cfg, 16'hBBBB); end
    n_checks++;
    if (log_addr.size() != 0) begin n_fail++; $display("FAIL chk_nowrite: got %0d expected 0", log_addr.size()); end
  endtask
`endif

  task automatic test_reset_mid();
    q_hdr(16'h1103); wq.push_back(16'h1111); wq.push_back(16'h2222); wq.push_back(16'h3333);
    send_q();
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (reg_wr !== 1'b0) begin n_fail++; $display("FAIL midreset_wr: got %b expected 0", reg_wr); end
    n_checks++;
    if ({vio_dout, vio_cfg} !== {16'hA000, 16'h0000}) begin
      n_fail++; $display("FAIL midreset_state: got %h/%h expected A000/0000", vio_dout, vio_cfg);
    end
    clear_log();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (log_addr.size() != 0) begin n_fail++; $display("FAIL midreset_nowrite: got %0d expected 0", log_addr.size()); end
    n_checks++;
    if (vio_dout !== 16'hA000) begin n_fail++; $display("FAIL midreset_idle: got %h expected %h", vio_dout, 16'hA000); end
  endtask

  initial begin
    reset_n    = 1'b0;
    vio_en     = 1'b0;
    vio_strobe = 1'b0;
    vio_din    = '0;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    vio_en  = 1'b1;
    @(negedge clk);
    test_write();
    test_read();
    test_wrap();
    test_overflow();
    test_bad_op();
    test_disable();
`ifdef VIO_HDR_CHECK_EN
    test_check();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
